uart_word_tx: RTL and testbench

- Synthesizable, parametrised UART word serializer for the SoC instruction-load path.
- Accepts WORD_W-bit words over a valid/ready handshake and splits each word into bytes.
- Transmits each byte as an 8N1/8N2 frame (optionally with parity) on a single line that drives the SoC's uart_rx_inst loader input.
- Generalises the simulation-only byte streamer: configurable width, baud, byte order and stop bits, with backpressure and status outputs.

---
 rtl/uart_word_tx.sv | 189 ++++++++++++++++++
 tb/tb_uart_word_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx: splits WORD_W-bit words into bytes and serialises each byte as a UART frame
// (start, 8 data bits LSB-first, STOP_BITS stop bits). Define UART_WORD_TX_PARITY_EN to add an even-parity bit.
module uart_word_tx #(
    parameter int WORD_W         = 32,
    parameter int CLK_FREQ       = 100000000,
    parameter int BAUD           = 9600,
    parameter int STOP_BITS      = 1,
    parameter bit LSB_BYTE_FIRST = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              word_valid_i,
    input  logic [WORD_W-1:0] word_i,
    output logic              word_ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              byte_done_o,
    output logic              word_done_o,
    output logic [CNT_W-1:0]  words_sent_o
);

    localparam int NB           = WORD_W / 8;
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD + 1;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W       = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NB - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_WORD_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    if ((WORD_W % 8 != 0) || (WORD_W < 8)) begin : g_bad_word_w
        $error("uart_word_tx: WORD_W must be a multiple of 8 and at least 8");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("uart_word_tx: STOP_BITS must be 1 or 2");
    end

    logic [2:0]        r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [BYTE_W-1:0] r_byte_idx;
    logic              r_stop_idx;
    logic [WORD_W-1:0] r_shift;
    logic              r_tx;
    logic [CNT_W-1:0]  r_words;

    logic [2:0]        w_state_nxt;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [2:0]        w_bit_nxt;
    logic [BYTE_W-1:0] w_byte_nxt;
    logic              w_stop_nxt;
    logic [WORD_W-1:0] w_shift_nxt;
    logic [WORD_W-1:0] w_shift_adv;
    logic [7:0]        w_nxt_byte;
    logic              w_tx_nxt;
    logic              w_bit_end;
    logic              w_last_stop;
    logic              w_last_byte;

    // The byte on air is always at the same end of the shift register; advancing moves the next one in.
    if (LSB_BYTE_FIRST) begin : g_lsb_first
        assign w_nxt_byte  = w_shift_nxt[7:0];
        assign w_shift_adv = r_shift >> 8;
    end else begin : g_msb_first
        assign w_nxt_byte  = w_shift_nxt[WORD_W-1 -: 8];
        assign w_shift_adv = r_shift << 8;
    end

    assign w_bit_end   = (r_baud == BAUD_LAST);
    assign w_last_byte = (r_byte_idx == BYTE_LAST);
    assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_stop_idx == STOP_LAST);

    // NOTE: every signal written in an always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_bit_end ? '0 : r_baud + 1'b1;
        w_bit_nxt   = r_bit_idx;
        w_byte_nxt  = r_byte_idx;
        w_stop_nxt  = r_stop_idx;
        w_shift_nxt = r_shift;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (word_valid_i) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = word_i;
                    w_byte_nxt  = '0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_WORD_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                        w_stop_nxt  = 1'b0;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_WORD_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_stop_nxt  = 1'b0;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_stop_idx != STOP_LAST) begin
                        w_stop_nxt = 1'b1;
                    end else if (!w_last_byte) begin
                        w_state_nxt = S_START;
                        w_byte_nxt  = r_byte_idx + 1'b1;
                        w_shift_nxt = w_shift_adv;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // tx_o is registered: compute the level the line must carry in the coming state.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_nxt_byte[w_bit_nxt];
`ifdef UART_WORD_TX_PARITY_EN
            S_PARITY: w_tx_nxt = ^w_nxt_byte;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_words    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud     <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_byte_idx <= w_byte_nxt;
            r_stop_idx <= w_stop_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            if (w_last_stop && w_last_byte) begin
                r_words <= r_words + 1'b1;
            end
        end
    end

    assign word_ready_o = (r_state == S_IDLE);
    assign busy_o       = (r_state != S_IDLE);
    assign tx_o         = r_tx;
    assign byte_done_o  = w_last_stop;
    assign word_done_o  = w_last_stop && w_last_byte;
    assign words_sent_o = r_words;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: three instances (LSB-first, MSB-first, 8-bit with two stop bits)
// checked cycle by cycle against a frame-level reference model, plus a table of hand-derived vectors.
module tb_uart_word_tx;

    localparam int CLK_FREQ = 100;
    localparam int BAUD     = 10;
    localparam int CPB      = CLK_FREQ / BAUD + 1;
`ifdef UART_WORD_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    typedef struct {
        int          sel;
        logic [31:0] w;
        logic [7:0]  eb [4];
        int          nbytes;
        int          cycles;
    } vec_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic [2:0]  valid  = '0;
    logic [31:0] word_a = '0;
    logic [31:0] word_b = '0;
    logic [7:0]  word_c = '0;
    logic [2:0]  tx, ready, busy, bdone, wdone;
    logic [2:0]  ws_a;
    logic [15:0] ws_b, ws_c;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_ws [3];
    bit          exp_bits [$];
    logic [7:0]  got_bytes [4];
    int          meas;
    vec_t        vecs [4];

    always #5 clk = ~clk;

    uart_word_tx #(.WORD_W(32), .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .STOP_BITS(1),
                   .LSB_BYTE_FIRST(1'b1), .CNT_W(3)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .word_valid_i(valid[0]), .word_i(word_a),
        .word_ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]), .byte_done_o(bdone[0]),
        .word_done_o(wdone[0]), .words_sent_o(ws_a));

    uart_word_tx #(.WORD_W(32), .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .STOP_BITS(1),
                   .LSB_BYTE_FIRST(1'b0), .CNT_W(16)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .word_valid_i(valid[1]), .word_i(word_b),
        .word_ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]), .byte_done_o(bdone[1]),
        .word_done_o(wdone[1]), .words_sent_o(ws_b));

    uart_word_tx #(.WORD_W(8), .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .STOP_BITS(2),
                   .LSB_BYTE_FIRST(1'b1), .CNT_W(16)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .word_valid_i(valid[2]), .word_i(word_c),
        .word_ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]), .byte_done_o(bdone[2]),
        .word_done_o(wdone[2]), .words_sent_o(ws_c));

    function automatic int nb_of(input int sel);
        return (sel == 2) ? 1 : 4;
    endfunction

    function automatic int stop_of(input int sel);
        return (sel == 2) ? 2 : 1;
    endfunction

    function automatic int ws_mask(input int sel);
        return (sel == 0) ? 7 : 65535;
    endfunction

    function automatic logic [31:0] ws_of(input int sel);
        case (sel)
            0:       return {29'b0, ws_a};
            1:       return {16'b0, ws_b};
            default: return {16'b0, ws_c};
        endcase
    endfunction

    // Reference model: the whole word as a list of line levels, one entry per bit time.
    function automatic void build_frame(input int sel, input logic [31:0] w);
        logic [7:0] b;
        int         pos;
        exp_bits.delete();
        for (int k = 0; k < nb_of(sel); k++) begin
            pos = (sel == 1) ? (nb_of(sel) - 1 - k) : k;
            b   = 8'((w >> (8 * pos)) & 32'hFF);
            exp_bits.push_back(1'b0);
            for (int j = 0; j < 8; j++) exp_bits.push_back(b[j]);
            if (PAR_BITS == 1) exp_bits.push_back(^b);
            for (int s = 0; s < stop_of(sel); s++) exp_bits.push_back(1'b1);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_word(input int sel, input logic [31:0] w);
        case (sel)
            0:       word_a = w;
            1:       word_b = w;
            default: word_c = w[7:0];
        endcase
    endtask

    task automatic check_all_idle(input string tag);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("%s dut%0d ready/busy/tx/bdone/wdone", tag, s),
                  {27'b0, ready[s], busy[s], tx[s], bdone[s], wdone[s]}, 32'b10100);
            check($sformatf("%s dut%0d words_sent", tag, s), ws_of(s), 32'd0);
        end
    endtask

    // Offers one word at the next edge and checks every following cycle against the model.
    // Called and returns at #1 after a rising edge.
    task automatic send_word(input int sel, input logic [31:0] w, input bit hold);
        int fb, total, good, n, p, k;
        bit e_bd, e_wd, e_tx;
        build_frame(sel, w);
        fb    = 9 + PAR_BITS + stop_of(sel);
        total = exp_bits.size() * CPB;
        k     = 0;
        while (ready[sel] !== 1'b1 && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        check($sformatf("dut%0d ready before offer", sel), {31'b0, ready[sel]}, 32'd1);
        set_word(sel, w);
        valid[sel] = 1'b1;
        @(posedge clk); #1;
        if (!hold) valid[sel] = 1'b0;
        set_word(sel, $urandom);
        meas = -1;
        n    = 0;
        for (int i = 0; i < 4; i++) got_bytes[i] = 8'h00;
        for (int b = 0; b < exp_bits.size(); b++) begin
            good = 0;
            e_tx = exp_bits[b];
            p    = b % fb;
            for (int c = 0; c < CPB; c++) begin
                e_bd = ((n + 1) % (fb * CPB)) == 0;
                e_wd = (n == total - 1);
                if (ready[sel] === 1'b1 && meas < 0) meas = n;
                if (tx[sel] === e_tx && busy[sel] === 1'b1 && ready[sel] === 1'b0 &&
                    bdone[sel] === e_bd && wdone[sel] === e_wd) good++;
                if (c == CPB / 2 && p >= 1 && p <= 8) got_bytes[b / fb][p - 1] = tx[sel];
                n++;
                @(posedge clk); #1;
            end
            check($sformatf("dut%0d word %h bit %0d good cycles", sel, w, b), good, CPB);
        end
        exp_ws[sel] = (exp_ws[sel] + 1) & ws_mask(sel);
        if (ready[sel] === 1'b1 && meas < 0) meas = n;
        check($sformatf("dut%0d word %h end ready/busy/tx/bdone/wdone", sel, w),
              {27'b0, ready[sel], busy[sel], tx[sel], bdone[sel], wdone[sel]}, 32'b10100);
        check($sformatf("dut%0d word %h words_sent", sel, w), ws_of(sel), exp_ws[sel]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{sel: 0, w: 32'h00201013, eb: '{8'h13, 8'h10, 8'h20, 8'h00}, nbytes: 4,
                    cycles: (PAR_BITS == 1) ? 484 : 440};
        vecs[1] = '{sel: 1, w: 32'h00201013, eb: '{8'h00, 8'h20, 8'h10, 8'h13}, nbytes: 4,
                    cycles: (PAR_BITS == 1) ? 484 : 440};
        vecs[2] = '{sel: 2, w: 32'h00000007, eb: '{8'h07, 8'h00, 8'h00, 8'h00}, nbytes: 1,
                    cycles: (PAR_BITS == 1) ? 132 : 121};
        vecs[3] = '{sel: 0, w: 32'hDEADBEEF, eb: '{8'hEF, 8'hBE, 8'hAD, 8'hDE}, nbytes: 4,
                    cycles: (PAR_BITS == 1) ? 484 : 440};
        for (int s = 0; s < 3; s++) exp_ws[s] = 0;

        #1 rst_n = 1'b0;
        #2;
        check_all_idle("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with hand-derived byte order and word duration.
        for (int v = 0; v < 4; v++) begin
            send_word(vecs[v].sel, vecs[v].w, 1'b0);
            for (int k = 0; k < vecs[v].nbytes; k++)
                check($sformatf("vec%0d byte %0d", v, k), {24'b0, got_bytes[k]}, {24'b0, vecs[v].eb[k]});
            check($sformatf("vec%0d word duration", v), meas, vecs[v].cycles);
        end

        // Random words with random idle gaps; dut0 runs far enough to wrap its 3-bit counter.
        for (int i = 0; i < 10; i++) begin
            int sel;
            sel = (i < 6) ? 0 : ((i < 8) ? 1 : 2);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send_word(sel, $urandom, 1'b0);
        end

        // Back-to-back: word_valid_i held high across two words.
        send_word(0, $urandom, 1'b1);
        send_word(0, $urandom, 1'b0);

        // Reset during DATA of byte 2.
        word_a   = 32'h12345678;
        valid[0] = 1'b1;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        repeat (240) @(posedge clk);
        #3;
        check("pre-reset busy/tx", {30'b0, busy[0], tx[0]}, 32'b10);
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) exp_ws[s] = 0;
        check_all_idle("mid-frame reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_word(0, 32'hA5A5A5A5, 1'b0);
        for (int k = 0; k < 4; k++)
            check($sformatf("post-reset byte %0d", k), {24'b0, got_bytes[k]}, 32'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
